if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage of the five-stage pipeline, directly upstream of ID. It holds the PC and reads instructions from Ram2 (program SRAM, asynchronous read). It predicts B/BEQZ/BNEZ with a bimodal table of 2-bit counters and registers the fetched instruction into the IF/ID latch. It accepts stall, flush and redirect commands from the hazard unit and ID, plus predictor updates from ID.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
BHT_BITS, 4, log2 of predictor entries; index = pc[BHT_BITS-1:0].
NOP_INSTR, 16'h0800, bubble instruction inserted on flush or redirect.

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  synchronous active-low reset.
hold_i  in  1  load-use stall; freezes PC and IF/ID.
flush_i  in  1  hazard-unit IF flush; IF/ID loads NOP.
redirect_i  in  1  JR or branch misprediction; PC loads redirect_addr_i.
redirect_addr_i  in  16  corrected fetch address.
upd_i  in  1  ID resolved a conditional/unconditional branch this cycle.
upd_pc_i  in  16  PC of the resolved branch.
upd_taken_i  in  1  actual outcome of the resolved branch.
Ram2Addr  out  18  SRAM address = {2'b00, pc}.
Ram2Data  inout  16  SRAM data; always driven 'z' by this block.
Ram2OE  out  1  constant 0 (read).
Ram2WE  out  1  constant 1.
Ram2EN  out  1  constant 0.
instr_o  out  16  IF/ID instruction.
pc_o  out  16  IF/ID PC of instr_o (EPC source).
pcplus1_o  out  16  IF/ID pc_o+1 (MFPC and not-taken recovery).
pred_taken_o  out  1  IF/ID prediction made for instr_o.

Behaviour:
- Reset (rst==0 at a rising edge): pc=RESET_PC; instr_o=NOP_INSTR; pc_o=0; pcplus1_o=0; pred_taken_o=0; every BHT entry=2'b01 (weakly not-taken). Reset overrides every other input, including in the middle of a stall or redirect.
- Fetch is single-cycle. Ram2Addr follows pc combinationally. Ram2Data is sampled at the next rising edge. Instruction latency from PC to instr_o is 1 cycle.
- Predecode of Ram2Data in the same cycle:
  - B: op[15:11]=00010; target = pc+1+sext(imm[10:0]); always predicted taken.
  - BEQZ (00100) / BNEZ (00101): target = pc+1+sext(imm[7:0]); predicted taken iff BHT[idx][1]==1.
  - Any other opcode: predicted not-taken.
- Next-PC priority at each rising edge (rst high):
  1. redirect_i: pc<=redirect_addr_i; instr_o<=NOP_INSTR; pred_taken_o<=0; pc_o, pcplus1_o<=0.
  2. flush_i: pc advances normally (predicted); IF/ID loads NOP with pred_taken_o=0.
  3. hold_i: pc and all IF/ID outputs keep their values.
  4. Otherwise: pc<=predicted target or pc+1. instr_o<=Ram2Data; pc_o<=pc; pcplus1_o<=pc+1; pred_taken_o<=prediction.
- redirect_i together with hold_i: redirect wins. flush_i together with hold_i: PC holds and IF/ID loads NOP.
- PC arithmetic is modulo 2^16: 16'hFFFF+1=16'h0000. Branch targets wrap the same way.
- BHT update: when upd_i=1 and rst=1, counter at upd_pc_i[BHT_BITS-1:0] increments (saturate at 3) if upd_taken_i, else decrements (saturate at 0). Update is independent of hold/flush/redirect. Same-cycle read of the same entry returns the old value (no bypass).
- B instructions also update the table; this is harmless.
- Ram2 control is constant. The block never drives Ram2Data.

Test Plan:
- Reset with RAM[0..3]=0x4901,0x4902,0x0800,0x0800, then release → pc 0,1,2,3. instr_o=0x4901 with pc_o=0, pcplus1_o=1 one cycle after release. Ram2OE=0, Ram2WE=1, Ram2EN=0 throughout.
- RAM[5]=0x1003 (B +3) → pred_taken_o=1 with instr_o=0x1003, then next fetch address 0x0009.
- RAM[8]=0x2102 (BEQZ R1,+2), BHT default → not taken, next pc 0x0009. Apply upd_i with pc 8 and taken=1, twice. Refetch 8 → pred_taken_o=1, next pc 0x000B. Then apply not-taken twice → counter back to 1.
- hold_i high for 3 cycles at pc=0x0010 → Ram2Addr stays 0x00010 and instr_o/pc_o unchanged. Release → pc 0x0011.
- redirect_i with addr 0x0040 while hold_i=1 and flush_i=1 → next pc 0x0040, instr_o=0x0800, pred_taken_o=0.
- pc=0xFFFF with a non-branch instruction → next pc 0x0000. Drive rst low during a redirect cycle → pc=RESET_PC and all BHT entries read back 2'b01.

Source files
------------

// File: rtl/if_stage_if.sv
// if_stage_if: control and IF/ID bundle between the fetch stage and its
// neighbours (hazard unit / ID).
//   hold_i, flush_i, redirect_i, redirect_addr_i : pipeline control into IF
//   upd_i, upd_pc_i, upd_taken_i                 : branch resolution from ID
//   instr_o, pc_o, pcplus1_o, pred_taken_o       : IF/ID latch contents
// master = hazard/ID side, slave = fetch stage.
interface if_stage_if;
   logic        hold_i;
   logic        flush_i;
   logic        redirect_i;
   logic [15:0] redirect_addr_i;
   logic        upd_i;
   logic [15:0] upd_pc_i;
   logic        upd_taken_i;
   logic [15:0] instr_o;
   logic [15:0] pc_o;
   logic [15:0] pcplus1_o;
   logic        pred_taken_o;

   modport master (
      output hold_i, flush_i, redirect_i, redirect_addr_i,
      output upd_i, upd_pc_i, upd_taken_i,
      input  instr_o, pc_o, pcplus1_o, pred_taken_o
   );

   modport slave (
      input  hold_i, flush_i, redirect_i, redirect_addr_i,
      input  upd_i, upd_pc_i, upd_taken_i,
      output instr_o, pc_o, pcplus1_o, pred_taken_o
   );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch. Holds the PC, reads Ram2 asynchronously,
// predicts B/BEQZ/BNEZ with a bimodal table of 2-bit counters and registers
// the fetched word into the IF/ID latch.
//   clk, rst      : clock, synchronous active-low reset
//   ifid (slave)  : stall/flush/redirect, predictor update, IF/ID outputs
//   Ram2Addr      : {2'b00, pc}
//   Ram2Data      : SRAM data, only read here (driven 'z')
//   Ram2OE/WE/EN  : constant read strobes 0/1/0
module if_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int          BHT_BITS  = 4,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   if_stage_if.slave   ifid,
   output logic [17:0] Ram2Addr,
   inout  wire  [15:0] Ram2Data,
   output logic        Ram2OE,
   output logic        Ram2WE,
   output logic        Ram2EN
);

   localparam int BHT_N = 2 ** BHT_BITS;

   logic [15:0] pc_q, pc_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] pco_q, pco_d;
   logic [15:0] pcp1_q, pcp1_d;
   logic        pred_q, pred_d;
   logic [1:0]  bht_q [BHT_N];

   assign Ram2Addr = {2'b00, pc_q};
   assign Ram2Data = 'z;
   assign Ram2OE   = 1'b0;
   assign Ram2WE   = 1'b1;
   assign Ram2EN   = 1'b0;

   // Predecode of the word arriving this cycle
   logic [4:0]          op;
   logic                is_b, is_bc, pred_tk;
   logic [15:0]         pc_plus1, off_b, off_c, npc_pred;
   logic [BHT_BITS-1:0] rd_idx, upd_idx;

   assign op       = Ram2Data[15:11];
   assign is_b     = (op == 5'b00010);
   assign is_bc    = (op == 5'b00100) || (op == 5'b00101);
   assign rd_idx   = pc_q[BHT_BITS-1:0];
   assign upd_idx  = ifid.upd_pc_i[BHT_BITS-1:0];
   assign pc_plus1 = pc_q + 16'd1;
   assign off_b    = {{5{Ram2Data[10]}}, Ram2Data[10:0]};
   assign off_c    = {{8{Ram2Data[7]}}, Ram2Data[7:0]};
   // Unconditional B is always taken; conditional uses the counter MSB
   assign pred_tk  = is_b || (is_bc && bht_q[rd_idx][1]);
   assign npc_pred = !pred_tk ? pc_plus1 :
                     is_b     ? pc_plus1 + off_b : pc_plus1 + off_c;

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pco_d   = pco_q;
      pcp1_d  = pcp1_q;
      pred_d  = pred_q;
      if (ifid.redirect_i) begin
         pc_d    = ifid.redirect_addr_i;
         instr_d = NOP_INSTR;
         pco_d   = '0;
         pcp1_d  = '0;
         pred_d  = 1'b0;
      end else if (ifid.flush_i) begin
         // A stall still freezes the PC; only the latch takes the bubble
         if (!ifid.hold_i) pc_d = npc_pred;
         instr_d = NOP_INSTR;
         pco_d   = '0;
         pcp1_d  = '0;
         pred_d  = 1'b0;
      end else if (!ifid.hold_i) begin
         pc_d    = npc_pred;
         instr_d = Ram2Data;
         pco_d   = pc_q;
         pcp1_d  = pc_plus1;
         pred_d  = pred_tk;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         pco_q   <= '0;
         pcp1_q  <= '0;
         pred_q  <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pco_q   <= pco_d;
         pcp1_q  <= pcp1_d;
         pred_q  <= pred_d;
      end
   end

   // Saturating counters; the read above sees the pre-update value
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
      end else if (ifid.upd_i) begin
         if (ifid.upd_taken_i) begin
            if (bht_q[upd_idx] != 2'b11) bht_q[upd_idx] <= bht_q[upd_idx] + 2'd1;
         end else begin
            if (bht_q[upd_idx] != 2'b00) bht_q[upd_idx] <= bht_q[upd_idx] - 2'd1;
         end
      end
   end

   assign ifid.instr_o      = instr_q;
   assign ifid.pc_o         = pco_q;
   assign ifid.pcplus1_o    = pcp1_q;
   assign ifid.pred_taken_o = pred_q;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed walk through fetch/predict/stall/redirect/reset,
// then randomized control and memory against a behavioural model.
module tb_if_stage;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [17:0] ram2_addr;
   wire  [15:0] ram2_data;
   logic        oe, we, en;
   logic [15:0] mem [0:65535];

   if_stage_if ifc ();

   assign ram2_data = mem[ram2_addr[15:0]];

   if_stage dut (
      .clk      (clk),
      .rst      (rst),
      .ifid     (ifc),
      .Ram2Addr (ram2_addr),
      .Ram2Data (ram2_data),
      .Ram2OE   (oe),
      .Ram2WE   (we),
      .Ram2EN   (en)
   );

   int errs = 0;
   int checks = 0;

   // model state
   logic [15:0] m_pc, m_instr, m_pco, m_pcp1;
   logic        m_pred;
   int          m_bht [16];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One rising edge of the reference model, using the inputs now applied
   task automatic model_edge();
      logic [15:0] ins, nxt;
      int          off, cnt, ui;
      bit          tk;
      if (!rst) begin
         m_pc = 16'h0000; m_instr = 16'h0800; m_pco = 0; m_pcp1 = 0; m_pred = 0;
         for (int i = 0; i < 16; i++) m_bht[i] = 1;
         return;
      end
      ins = mem[m_pc];
      cnt = m_bht[int'(m_pc) % 16];
      tk  = 0;
      off = 0;
      if (ins[15:11] == 5'b00010) begin
         tk  = 1;
         off = ins[10] ? int'(ins[10:0]) - 2048 : int'(ins[10:0]);
      end else if (ins[15:11] == 5'b00100 || ins[15:11] == 5'b00101) begin
         tk  = (cnt >= 2);
         off = ins[7] ? int'(ins[7:0]) - 256 : int'(ins[7:0]);
      end
      nxt = tk ? 16'(int'(m_pc) + 1 + off) : 16'(int'(m_pc) + 1);
      if (ifc.redirect_i) begin
         m_pc = ifc.redirect_addr_i; m_instr = 16'h0800; m_pco = 0; m_pcp1 = 0; m_pred = 0;
      end else if (ifc.flush_i) begin
         if (!ifc.hold_i) m_pc = nxt;
         m_instr = 16'h0800; m_pco = 0; m_pcp1 = 0; m_pred = 0;
      end else if (!ifc.hold_i) begin
         m_instr = ins; m_pco = m_pc; m_pcp1 = 16'(int'(m_pc) + 1); m_pred = tk;
         m_pc = nxt;
      end
      if (ifc.upd_i) begin
         ui = int'(ifc.upd_pc_i) % 16;
         if (ifc.upd_taken_i) m_bht[ui] = (m_bht[ui] < 3) ? m_bht[ui] + 1 : 3;
         else                 m_bht[ui] = (m_bht[ui] > 0) ? m_bht[ui] - 1 : 0;
      end
   endtask

   task automatic cyc(input bit r, input bit h, input bit f, input bit rd,
                      input logic [15:0] ra, input bit u, input logic [15:0] up,
                      input bit ut);
      rst = r;
      ifc.hold_i = h; ifc.flush_i = f; ifc.redirect_i = rd; ifc.redirect_addr_i = ra;
      ifc.upd_i = u; ifc.upd_pc_i = up; ifc.upd_taken_i = ut;
      model_edge();
      @(posedge clk);
      #1;
      chk("addr",    ram2_addr, {2'b00, m_pc});
      chk("instr",   ifc.instr_o, m_instr);
      chk("pc_o",    ifc.pc_o, m_pco);
      chk("pcplus1", ifc.pcplus1_o, m_pcp1);
      chk("pred",    ifc.pred_taken_o, m_pred);
      chk("ram_ctl", {oe, we, en}, 3'b010);
   endtask

   task automatic idle();
      cyc(1, 0, 0, 0, 16'h0, 0, 16'h0, 0);
   endtask

   task automatic redir(input logic [15:0] a);
      cyc(1, 0, 0, 1, a, 0, 16'h0, 0);
   endtask

   task automatic upd(input logic [15:0] p, input bit t);
      cyc(1, 0, 0, 0, 16'h0, 1, p, t);
   endtask

   logic [15:0] saved;

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0800;
      mem[0] = 16'h4901; mem[1] = 16'h4902; mem[2] = 16'h0800; mem[3] = 16'h0800;
      mem[5] = 16'h1003;          // B +3 -> 9
      mem[8] = 16'h2102;          // BEQZ R1,+2 -> 11
      mem[16'h23] = 16'h2102;     // BEQZ, BHT entry 3
      mem[16'h25] = 16'h2d02;     // BNEZ, BHT entry 5
      rst = 0;
      ifc.hold_i = 0; ifc.flush_i = 0; ifc.redirect_i = 0; ifc.redirect_addr_i = 0;
      ifc.upd_i = 0; ifc.upd_pc_i = 0; ifc.upd_taken_i = 0;

      cyc(0, 0, 0, 0, 16'h0, 0, 16'h0, 0);
      cyc(0, 0, 0, 0, 16'h0, 0, 16'h0, 0);
      chk("rst_instr", ifc.instr_o, 16'h0800);
      idle();
      chk("first_instr", ifc.instr_o, 16'h4901);
      chk("first_pco",   ifc.pc_o, 16'h0000);
      chk("first_pcp1",  ifc.pcplus1_o, 16'h0001);
      for (int i = 0; i < 5; i++) idle();
      chk("b_instr", ifc.instr_o, 16'h1003);
      chk("b_pred",  ifc.pred_taken_o, 1'b1);
      chk("b_tgt",   ram2_addr, 18'h00009);

      redir(16'h0008); idle();
      chk("beqz_nt_pred", ifc.pred_taken_o, 1'b0);
      chk("beqz_nt_npc",  ram2_addr, 18'h00009);
      upd(16'h0008, 1); upd(16'h0008, 1);
      redir(16'h0008); idle();
      chk("beqz_t_pred", ifc.pred_taken_o, 1'b1);
      chk("beqz_t_npc",  ram2_addr, 18'h0000B);
      upd(16'h0008, 0); upd(16'h0008, 0);
      redir(16'h0008); idle();
      chk("beqz_back_pred", ifc.pred_taken_o, 1'b0);

      redir(16'h0010);
      saved = ifc.instr_o;
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 0, 0, 16'h0, 0, 16'h0, 0);
         chk("hold_addr",  ram2_addr, 18'h00010);
         chk("hold_instr", ifc.instr_o, saved);
      end
      idle();
      chk("hold_rel", ram2_addr, 18'h00011);

      cyc(1, 1, 1, 1, 16'h0040, 0, 16'h0, 0);
      chk("redir_addr",  ram2_addr, 18'h00040);
      chk("redir_instr", ifc.instr_o, 16'h0800);
      chk("redir_pred",  ifc.pred_taken_o, 1'b0);

      redir(16'hFFFF); idle();
      chk("wrap", ram2_addr, 18'h00000);

      // skew two counters away from the reset value, then reset mid-redirect
      upd(16'h0003, 1); upd(16'h0003, 1); upd(16'h0005, 0);
      cyc(0, 0, 0, 1, 16'h1234, 0, 16'h0, 0);
      chk("rst_redir_addr", ram2_addr, 18'h00000);
      redir(16'h0023); idle();
      chk("bht3_reset", ifc.pred_taken_o, 1'b0);
      upd(16'h0005, 1);
      redir(16'h0025); idle();
      chk("bht5_reset", ifc.pred_taken_o, 1'b1);

      // randomized phase
      for (int i = 0; i < 65536; i++) begin
         case ($urandom_range(0, 3))
            0:       mem[i] = {5'b00010, 11'($urandom)};
            1:       mem[i] = {4'b0010, 12'($urandom)};
            default: mem[i] = 16'($urandom);
         endcase
      end
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 99) >= 2,
             $urandom_range(0, 99) < 15,
             $urandom_range(0, 99) < 10,
             $urandom_range(0, 99) < 5,
             16'($urandom),
             $urandom_range(0, 99) < 40,
             16'($urandom),
             1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
